// File: rtl/fft_8pt_pkg.sv
// fft_8pt_pkg
// Shared definitions for the 8-point radix-2 DIT FFT:
//   - width constants (sample, work, twiddle, magnitude)
//   - complex work-value and twiddle struct types
//   - FSM state enum
//   - twiddle lookup (W^k = e^(-j*2*pi*k/8), Q1.14), bit-reverse index,
//     and the |re|+|im| magnitude with saturation.
package fft_8pt_pkg;

  localparam int DATA_W  = 16;  // input sample width
  localparam int WORK_W  = 24;  // internal complex component width
  localparam int TW_W    = 16;  // twiddle component width (Q1.14)
  localparam int TW_FRAC = 14;  // twiddle fraction bits
  localparam int MAG_W   = 16;  // published magnitude width
  localparam int N_PTS   = 8;   // transform length

  typedef struct packed {
    logic signed [WORK_W-1:0] re;
    logic signed [WORK_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } twid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Twiddle table W0..W3 in Q1.14.
  function automatic twid_t twiddle(input logic [1:0] k);
    twid_t w;
    case (k)
      2'd0:    begin w.re =  16'sd16384; w.im =  16'sd0;     end
      2'd1:    begin w.re =  16'sd11585; w.im = -16'sd11585; end
      2'd2:    begin w.re =  16'sd0;     w.im = -16'sd16384; end
      2'd3:    begin w.re = -16'sd11585; w.im = -16'sd11585; end
      default: begin w.re =  16'sd16384; w.im =  16'sd0;     end
    endcase
    return w;
  endfunction

  // Reverse the three index bits (load order x0,x4,x2,x6,x1,x5,x3,x7).
  function automatic logic [2:0] bit_rev3(input logic [2:0] idx);
    return {idx[0], idx[1], idx[2]};
  endfunction

  // |re| + |im|, clamped to the magnitude range. The negation of the most
  // negative work value is still correct when read back as unsigned.
  function automatic logic [MAG_W-1:0] mag_sat(input cplx_t c);
    logic [WORK_W-1:0] abs_re;
    logic [WORK_W-1:0] abs_im;
    logic [WORK_W:0]   sum;
    abs_re = c.re[WORK_W-1] ? WORK_W'(-c.re) : WORK_W'(c.re);
    abs_im = c.im[WORK_W-1] ? WORK_W'(-c.im) : WORK_W'(c.im);
    sum    = {1'b0, abs_re} + {1'b0, abs_im};
    if (|sum[WORK_W:MAG_W]) begin
      return {MAG_W{1'b1}};
    end else begin
      return sum[MAG_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fft_8pt_if.sv
// fft_8pt_if
// Bundles the FFT's sample bus, start request and magnitude outputs.
//   start                  : rising edge while idle requests one transform
//   data_in1..data_in8     : signed time samples x[0]..x[7]
//   data_out1..data_out8   : magnitude approximations of X[0]..X[7]
// master = front end / bench side, slave = the FFT block.
interface fft_8pt_if
  import fft_8pt_pkg::*;
;
  logic                     start;
  logic signed [DATA_W-1:0] data_in1, data_in2, data_in3, data_in4;
  logic signed [DATA_W-1:0] data_in5, data_in6, data_in7, data_in8;
  logic        [MAG_W-1:0]  data_out1, data_out2, data_out3, data_out4;
  logic        [MAG_W-1:0]  data_out5, data_out6, data_out7, data_out8;

  modport master (
    output start,
    output data_in1, data_in2, data_in3, data_in4,
    output data_in5, data_in6, data_in7, data_in8,
    input  data_out1, data_out2, data_out3, data_out4,
    input  data_out5, data_out6, data_out7, data_out8
  );

  modport slave (
    input  start,
    input  data_in1, data_in2, data_in3, data_in4,
    input  data_in5, data_in6, data_in7, data_in8,
    output data_out1, data_out2, data_out3, data_out4,
    output data_out5, data_out6, data_out7, data_out8
  );
endinterface

// File: rtl/fft_8pt_bfly.sv
// fft_8pt_bfly
// Combinational radix-2 DIT butterfly: t = B*W, A' = A + t, B' = A - t.
// Each product term is work x twiddle signed; the real/imag sums get a
// half-LSB added before the arithmetic shift (round half up) and are then
// truncated to the work width.
//   a_i, b_i : complex operands
//   w_i      : twiddle, Q1.14
//   a_o, b_o : butterfly results
module fft_8pt_bfly
  import fft_8pt_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  input  twid_t w_i,
  output cplx_t a_o,
  output cplx_t b_o
);

  localparam int PROD_W = WORK_W + TW_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] ROUND_C = SUM_W'(64'sd1 <<< (TW_FRAC - 1));

  logic signed [PROD_W-1:0] b_re_x, b_im_x, w_re_x, w_im_x;
  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SUM_W-1:0]  t_re_sum, t_im_sum;
  logic signed [WORK_W-1:0] t_re, t_im;

  // Sign-extend operands so each product is formed at full precision.
  assign b_re_x = PROD_W'(b_i.re);
  assign b_im_x = PROD_W'(b_i.im);
  assign w_re_x = PROD_W'(w_i.re);
  assign w_im_x = PROD_W'(w_i.im);

  assign p_rr = b_re_x * w_re_x;
  assign p_ii = b_im_x * w_im_x;
  assign p_ri = b_re_x * w_im_x;
  assign p_ir = b_im_x * w_re_x;

  assign t_re_sum = SUM_W'(p_rr) - SUM_W'(p_ii) + ROUND_C;
  assign t_im_sum = SUM_W'(p_ri) + SUM_W'(p_ir) + ROUND_C;

  assign t_re = WORK_W'(t_re_sum >>> TW_FRAC);
  assign t_im = WORK_W'(t_im_sum >>> TW_FRAC);

  // Sum/difference of A with the rotated B.
  always_comb begin
    a_o.re = a_i.re + t_re;
    a_o.im = a_i.im + t_im;
    b_o.re = a_i.re - t_re;
    b_o.im = a_i.im - t_im;
  end

endmodule

// File: rtl/fft_8pt.sv
// fft_8pt
// 8-point radix-2 decimation-in-time FFT over real signed 16-bit samples.
// A start rising edge while idle snapshots the eight inputs (bit-reversed)
// into the complex work registers; one shared butterfly then runs the
// 3 stages x 4 butterflies in place over 12 cycles, and the next cycle
// publishes |re|+|im| (saturated) for all eight bins at once. Outputs hold
// until the next transform completes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fft_8pt_if (start, data_in1..8, data_out1..8)
module fft_8pt
  import fft_8pt_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  fft_8pt_if.slave bus
);

  localparam logic [3:0] LAST_BFLY = 4'd11;

  state_t                            state_q, state_d;
  logic                              start_d_q;
  logic                              start_edge_s;
  logic [3:0]                        cnt_q, cnt_d;
  logic [1:0]                        stage_s, bfly_s;
  logic [2:0]                        top_idx_s, bot_idx_s;
  logic [1:0]                        tw_idx_s;
  twid_t                             tw_s;
  cplx_t                             bf_a_s, bf_b_s;
  cplx_t [N_PTS-1:0]                 work_q;
  cplx_t [N_PTS-1:0]                 load_s;
  logic  [N_PTS-1:0][DATA_W-1:0]     din_s;
  logic  [N_PTS-1:0][MAG_W-1:0]      mag_s;
  logic  [N_PTS-1:0][MAG_W-1:0]      data_out_q;

  // Accept a start edge only while idle; edges elsewhere are dropped.
  assign start_edge_s = bus.start & ~start_d_q & (state_q == ST_IDLE);

  assign din_s[0] = bus.data_in1;
  assign din_s[1] = bus.data_in2;
  assign din_s[2] = bus.data_in3;
  assign din_s[3] = bus.data_in4;
  assign din_s[4] = bus.data_in5;
  assign din_s[5] = bus.data_in6;
  assign din_s[6] = bus.data_in7;
  assign din_s[7] = bus.data_in8;

  // Previous start level, tracked in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d_q <= 1'b0;
    end else begin
      start_d_q <= bus.start;
    end
  end

  // FSM state and butterfly counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> CALC (12 butterflies) -> OUT (1 cycle) -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_CALC;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_BFLY) begin
          state_d = ST_OUT;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_CALC;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign stage_s = cnt_q[3:2];
  assign bfly_s  = cnt_q[1:0];

  // Pair addressing: span h = 2^stage; the butterfly number splits into a
  // group (upper bits) and an offset j inside the group; the partner sits
  // h above, and the twiddle index is j scaled by 4/h.
  always_comb begin
    top_idx_s = 3'd0;
    bot_idx_s = 3'd0;
    tw_idx_s  = 2'd0;
    case (stage_s)
      2'd0: begin
        top_idx_s = {bfly_s, 1'b0};
        bot_idx_s = {bfly_s, 1'b1};
        tw_idx_s  = 2'd0;
      end
      2'd1: begin
        top_idx_s = {bfly_s[1], 1'b0, bfly_s[0]};
        bot_idx_s = {bfly_s[1], 1'b1, bfly_s[0]};
        tw_idx_s  = {bfly_s[0], 1'b0};
      end
      2'd2: begin
        top_idx_s = {1'b0, bfly_s};
        bot_idx_s = {1'b1, bfly_s};
        tw_idx_s  = bfly_s;
      end
      default: begin
        top_idx_s = 3'd0;
        bot_idx_s = 3'd0;
        tw_idx_s  = 2'd0;
      end
    endcase
  end

  assign tw_s = twiddle(tw_idx_s);

  fft_8pt_bfly u_bfly (
    .a_i (work_q[top_idx_s]),
    .b_i (work_q[bot_idx_s]),
    .w_i (tw_s),
    .a_o (bf_a_s),
    .b_o (bf_b_s)
  );

  // Snapshot image: sign-extended samples in bit-reversed order, imag = 0.
  always_comb begin
    load_s = '0;
    for (int i = 0; i < N_PTS; i++) begin
      load_s[i].re = WORK_W'($signed(din_s[bit_rev3(3'(i))]));
      load_s[i].im = '0;
    end
  end

  // Work register file: loaded on acceptance, updated in place during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
    end else if (start_edge_s) begin
      work_q <= load_s;
    end else if (state_q == ST_CALC) begin
      work_q[top_idx_s] <= bf_a_s;
      work_q[bot_idx_s] <= bf_b_s;
    end
  end

  // Per-bin magnitude of the finished work registers.
  always_comb begin
    mag_s = '0;
    for (int k = 0; k < N_PTS; k++) begin
      mag_s[k] = mag_sat(work_q[k]);
    end
  end

  // Published magnitudes: all bins update together in OUT, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (state_q == ST_OUT) begin
      data_out_q <= mag_s;
    end
  end

  assign bus.data_out1 = data_out_q[0];
  assign bus.data_out2 = data_out_q[1];
  assign bus.data_out3 = data_out_q[2];
  assign bus.data_out4 = data_out_q[3];
  assign bus.data_out5 = data_out_q[4];
  assign bus.data_out6 = data_out_q[5];
  assign bus.data_out7 = data_out_q[6];
  assign bus.data_out8 = data_out_q[7];

endmodule

// File: tb/tb_fft_8pt.sv
// tb_fft_8pt
// Directed self-checking bench for fft_8pt. Expected magnitude vectors are
// either hand constants or produced by a fixed-point reference FFT written
// directly from the transform definition; they are queued when a start is
// driven and popped when the result is due at E13.
module tb_fft_8pt;

  typedef logic [7:0][15:0] vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  vec_t sb_q[$];
  vec_t last_exp;
  vec_t dut_out;
  vec_t v_a;
  vec_t v_b;
  vec_t e_v;

  fft_8pt_if bus ();

  fft_8pt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_out[0] = bus.data_out1;
  assign dut_out[1] = bus.data_out2;
  assign dut_out[2] = bus.data_out3;
  assign dut_out[3] = bus.data_out4;
  assign dut_out[4] = bus.data_out5;
  assign dut_out[5] = bus.data_out6;
  assign dut_out[6] = bus.data_out7;
  assign dut_out[7] = bus.data_out8;

  // Reference FFT: bit-reversed load, three in-place stages, Q1.14 twiddles
  // with round-half-up, then |re|+|im| clamped to 65535.
  function automatic vec_t fft_model(input vec_t x);
    longint re[8];
    longint im[8];
    longint wr[4];
    longint wi[4];
    longint tr, ti, m;
    int     h, k, ia, ib, rv;
    vec_t   y;
    wr[0] = 16384;  wi[0] = 0;
    wr[1] = 11585;  wi[1] = -11585;
    wr[2] = 0;      wi[2] = -16384;
    wr[3] = -11585; wi[3] = -11585;
    for (int n = 0; n < 8; n++) begin
      rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
      re[n] = longint'($signed(x[rv]));
      im[n] = 0;
    end
    for (int s = 0; s < 3; s++) begin
      h = 1 << s;
      for (int g = 0; g < 8; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          k  = j * (4 / h);
          ia = g + j;
          ib = ia + h;
          tr = (re[ib] * wr[k] - im[ib] * wi[k] + 8192) >>> 14;
          ti = (re[ib] * wi[k] + im[ib] * wr[k] + 8192) >>> 14;
          re[ib] = re[ia] - tr;
          im[ib] = im[ia] - ti;
          re[ia] = re[ia] + tr;
          im[ia] = im[ia] + ti;
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      m = (re[n] < 0 ? -re[n] : re[n]) + (im[n] < 0 ? -im[n] : im[n]);
      if (m > 65535) m = 65535;
      y[n] = 16'(m);
    end
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_inputs(input vec_t v);
    bus.data_in1 = v[0];
    bus.data_in2 = v[1];
    bus.data_in3 = v[2];
    bus.data_in4 = v[3];
    bus.data_in5 = v[4];
    bus.data_in6 = v[5];
    bus.data_in7 = v[6];
    bus.data_in8 = v[7];
  endtask

  task automatic chk(input string tag, input int bin, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s out%0d observed=%0d expected=%0d", tag, bin + 1, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t exp);
    for (int i = 0; i < 8; i++) chk(tag, i, dut_out[i], exp[i]);
  endtask

  // Pop the next scoreboard entry and compare all eight bins.
  task automatic chk_pop(input string tag);
    checks++;
    assert (sb_q.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() > 0) begin
      last_exp = sb_q.pop_front();
      chk_vec(tag, last_exp);
    end
  endtask

  // One plain transform: start for one cycle, outputs held through E12,
  // new result at E13.
  task automatic run_plain(input string tag, input vec_t x, input vec_t exp);
    set_inputs(x);
    sb_q.push_back(exp);
    bus.start = 1'b1;
    tick();                     // E0
    bus.start = 1'b0;
    ticks(12);                  // E1..E12
    chk(tag, 0, dut_out[0], last_exp[0]);
    tick();                     // E13
    chk_pop(tag);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    set_inputs('0);
    ticks(2);
    chk_vec("reset", '0);
    rst_n = 1'b1;
    ticks(2);

    // Step block, start held 3 cycles, inputs disturbed from E1 onward.
    v_a = '0;
    for (int i = 0; i < 4; i++) v_a[i] = 16'd128;
    set_inputs(v_a);
    sb_q.push_back(fft_model(v_a));
    bus.start = 1'b1;
    tick();                     // E0
    v_b = '0;
    for (int i = 0; i < 8; i++) v_b[i] = 16'(i * 911 - 3000);
    set_inputs(v_b);
    ticks(2);                   // E1, E2 with start still high
    bus.start = 1'b0;
    ticks(10);                  // E3..E12
    chk("step_hold", 0, dut_out[0], 16'd0);
    tick();                     // E13
    chk_pop("step");
    ticks(20);
    chk_vec("step_once", last_exp);

    // DC: all 100.
    v_a = '0;
    for (int i = 0; i < 8; i++) v_a[i] = 16'd100;
    e_v = '0;
    e_v[0] = 16'd800;
    run_plain("dc", v_a, e_v);

    // Impulse at x0 = -1000: flat spectrum of 1000.
    v_a = '0;
    v_a[0] = -16'sd1000;
    for (int i = 0; i < 8; i++) e_v[i] = 16'd1000;
    run_plain("imp_neg", v_a, e_v);

    // Impulse at x1 = 1000: diagonal twiddles give 707+707 on odd bins.
    v_a = '0;
    v_a[1] = 16'sd1000;
    for (int i = 0; i < 8; i++) e_v[i] = (i % 2 == 1) ? 16'd1414 : 16'd1000;
    run_plain("imp_x1", v_a, e_v);

    // Saturation.
    for (int i = 0; i < 8; i++) v_a[i] = 16'sd32767;
    e_v = '0;
    e_v[0] = 16'hFFFF;
    run_plain("sat", v_a, e_v);

    // Mixed signed pattern against the reference.
    v_a[0] = 16'sd5000;   v_a[1] = -16'sd7000; v_a[2] = 16'sd123;   v_a[3] = 16'sd32000;
    v_a[4] = -16'sd32768; v_a[5] = 16'sd1;     v_a[6] = -16'sd4321; v_a[7] = 16'sd2500;
    run_plain("mixed", v_a, fft_model(v_a));

    // Start edge at E5 during CALC is ignored; nothing is queued.
    v_a = '0;
    for (int i = 0; i < 8; i++) v_a[i] = 16'(i * 300);
    set_inputs(v_a);
    sb_q.push_back(fft_model(v_a));
    bus.start = 1'b1;
    tick();                     // E0
    bus.start = 1'b0;
    ticks(4);                   // E1..E4
    v_b = '0;
    v_b[0] = 16'sd20000;
    set_inputs(v_b);
    bus.start = 1'b1;
    tick();                     // E5
    bus.start = 1'b0;
    ticks(7);                   // E6..E12
    tick();                     // E13
    chk_pop("busy");
    ticks(20);
    chk_vec("busy_noqueue", last_exp);

    // Reset in mid-run: outputs clear at once, no result afterwards.
    v_a = '0;
    for (int i = 0; i < 8; i++) v_a[i] = 16'sd777;
    set_inputs(v_a);
    bus.start = 1'b1;
    tick();                     // E0
    bus.start = 1'b0;
    ticks(5);                   // E1..E5
    #2;
    rst_n = 1'b0;
    #1;
    last_exp = '0;
    chk_vec("rst_mid", '0);
    ticks(2);
    rst_n = 1'b1;
    ticks(20);
    chk_vec("rst_quiet", '0);

    // Fresh transform after reset still works.
    e_v = '0;
    e_v[0] = 16'd6216;
    run_plain("post_rst", v_a, e_v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
